kbd_seg: RTL and testbench

PS/2 keyboard receiver with make/break decoding and seven-segment readout for the NVBoard display chain. It deserialises PS/2 device-to-host frames, tracks which key is held, and counts distinct key presses. It drives eight 8-bit seven-segment outputs through the team's existing `seg` hex decoder: the held scan code, the press count, and blanks. It is the input-side counterpart of the button-driven shift/display block.

---
 rtl/kbd_pkg.sv | 18 +
 rtl/ps2_rx.sv | 97 +++++++++
 rtl/seg.sv | 37 +++
 rtl/kbd_seg.sv | 110 +++++++++++
 tb/tb_kbd_seg.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/kbd_pkg.sv
// kbd_pkg: shared types and constants for the PS/2 keyboard readout.
//   kbd_state_t : make/break decoder states
//   PS2_EXT     : extended-key prefix byte
//   PS2_BRK     : break (key release) prefix byte
//   FRAME_BITS  : PS/2 device-to-host frame length (start, 8 data, parity, stop)
//   SEG_BLANK   : segment pattern with every segment off (active-low display)
package kbd_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HELD  = 2'd1,
    BREAK = 2'd2
  } kbd_state_t;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam int         FRAME_BITS = 11;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;
endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver.
//   clk, rst      : system clock, asynchronous active-low reset
//   ps2_clk/data  : raw asynchronous PS/2 lines
//   byte_rdy      : one-cycle strobe for each good frame
//   byte_data     : data byte of the last good frame
//   err           : sticky start/stop/parity error flag
module ps2_rx
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_rdy,
  output logic [7:0] byte_data,
  output logic       err
);
  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_BIT = 4'(FRAME_BITS - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   data_q;
  logic [3:0]             bit_cnt;
  logic [TW-1:0]          idle_cnt;
  logic [9:0]             bits;
  logic [10:0]            frame;
  logic                   frame_ok;

  // The ten earlier bits plus the one arriving now; frame[0] is the start bit.
  assign frame    = {data_q, bits};
  assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

  // Synchroniser and registered falling-edge detect. Lines idle high, so
  // the chain resets to ones and no false edge appears on reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
      fall      <= 1'b0;
      data_q    <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
      fall      <= clk_prev & ~clk_sync[SYNC_STAGES-1];
      data_q    <= data_sync[SYNC_STAGES-1];
    end
  end

  // Bit counter, frame check and mid-frame timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt  <= '0;
      idle_cnt <= '0;
      byte_rdy <= 1'b0;
      err      <= 1'b0;
    end else begin
      byte_rdy <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt <= '0;
          if (frame_ok) byte_rdy <= 1'b1;
          else          err      <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        // A stalled frame is dropped quietly so the next start bit realigns.
        if (idle_cnt == IDLE_MAX) begin
          bit_cnt  <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + TW'(1);
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  // Shift register: newest bit enters at the top, LSB-first order.
  always_ff @(posedge clk) begin
    if (fall) begin
      bits <= {data_q, bits[9:1]};
      if (bit_cnt == LAST_BIT) byte_data <= frame[8:1];
    end
  end
endmodule

// File: rtl/seg.sv
// seg: hex digit to seven-segment decoder for the NVBoard display chain.
//   hex  in 4 : digit to show
//   en   in 1 : 0 forces the blank pattern
//   segs out 8: active-low segments, bit order {a,b,c,d,e,f,g,dp}
module seg
  import kbd_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       en,
  output logic [7:0] segs
);
  logic [7:0] lit;

  always_comb begin
    lit = 8'h00;
    case (hex)
      4'h0: lit = 8'hFC;
      4'h1: lit = 8'h60;
      4'h2: lit = 8'hDA;
      4'h3: lit = 8'hF2;
      4'h4: lit = 8'h66;
      4'h5: lit = 8'hB6;
      4'h6: lit = 8'hBE;
      4'h7: lit = 8'hE0;
      4'h8: lit = 8'hFE;
      4'h9: lit = 8'hF6;
      4'hA: lit = 8'hEE;
      4'hB: lit = 8'h3E;
      4'hC: lit = 8'h9C;
      4'hD: lit = 8'h7A;
      4'hE: lit = 8'h9E;
      4'hF: lit = 8'h8E;
      default: lit = 8'h00;
    endcase
    segs = en ? ~lit : SEG_BLANK;
  end
endmodule

// File: rtl/kbd_seg.sv
// kbd_seg: PS/2 keyboard make/break decoder with seven-segment readout.
//   clk, rst       : system clock, asynchronous active-low reset
//   ps2_clk/data   : raw PS/2 keyboard lines
//   key_valid      : one-cycle pulse per registered key press
//   key_code       : scan code of the held key, 0x00 when released
//   frame_err      : sticky receive error flag
//   seg_0..seg_7   : segment patterns; 1:0 key code (HELD only),
//                    5:4 press count, others blank
module kbd_seg
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       frame_err,
  output logic [7:0] seg_0,
  output logic [7:0] seg_1,
  output logic [7:0] seg_2,
  output logic [7:0] seg_3,
  output logic [7:0] seg_4,
  output logic [7:0] seg_5,
  output logic [7:0] seg_6,
  output logic [7:0] seg_7
);
  logic       byte_rdy;
  logic [7:0] byte_data;
  kbd_state_t state, state_nx;
  logic [7:0] code_nx;
  logic [7:0] count, count_nx;
  logic       valid_nx;
  logic       held;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .byte_rdy (byte_rdy),
    .byte_data(byte_data),
    .err      (frame_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      key_code  <= 8'h00;
      count     <= 8'h00;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      key_code  <= code_nx;
      count     <= count_nx;
      key_valid <= valid_nx;
    end
  end

  always_comb begin
    state_nx = state;
    code_nx  = key_code;
    count_nx = count;
    valid_nx = 1'b0;
    // The extended prefix carries no information for this display.
    if (byte_rdy && byte_data != PS2_EXT) begin
      if (byte_data == PS2_BRK) begin
        state_nx = BREAK;
      end else begin
        case (state)
          BREAK: begin
            state_nx = IDLE;
            code_nx  = 8'h00;
          end
          HELD: begin
            // Same code again is typematic repeat, not a new press.
            if (byte_data != key_code) begin
              code_nx  = byte_data;
              count_nx = count + 8'd1;
              valid_nx = 1'b1;
            end
          end
          default: begin
            state_nx = HELD;
            code_nx  = byte_data;
            count_nx = count + 8'd1;
            valid_nx = 1'b1;
          end
        endcase
      end
    end
  end

  assign held = (state == HELD);

  seg u_seg0 (.hex(key_code[3:0]), .en(held), .segs(seg_0));
  seg u_seg1 (.hex(key_code[7:4]), .en(held), .segs(seg_1));
  seg u_seg2 (.hex(4'h0),          .en(1'b0), .segs(seg_2));
  seg u_seg3 (.hex(4'h0),          .en(1'b0), .segs(seg_3));
  seg u_seg4 (.hex(count[3:0]),    .en(1'b1), .segs(seg_4));
  seg u_seg5 (.hex(count[7:4]),    .en(1'b1), .segs(seg_5));
  seg u_seg6 (.hex(4'h0),          .en(1'b0), .segs(seg_6));
  seg u_seg7 (.hex(4'h0),          .en(1'b0), .segs(seg_7));
endmodule

// File: tb/tb_kbd_seg.sv
// tb_kbd_seg: scoreboard bench for kbd_seg with a behavioural keyboard model.
`timescale 1ns/1ps
module tb_kbd_seg;
  localparam int TO = 300;
  localparam int SS = 3;
  localparam int H  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_valid;
  logic [7:0] key_code;
  logic       frame_err;
  logic [7:0] seg_0, seg_1, seg_2, seg_3, seg_4, seg_5, seg_6, seg_7;

  kbd_seg #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_valid(key_valid), .key_code(key_code), .frame_err(frame_err),
    .seg_0(seg_0), .seg_1(seg_1), .seg_2(seg_2), .seg_3(seg_3),
    .seg_4(seg_4), .seg_5(seg_5), .seg_6(seg_6), .seg_7(seg_7)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: 0 = nothing held, 1 = key held, 2 = release prefix seen
  int         m_state;
  logic [7:0] m_code;
  logic [7:0] m_count;
  logic       m_err;

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] count;
  } press_t;
  press_t exp_q[$];

  function automatic logic [7:0] font(input logic [3:0] h);
    logic [7:0] p;
    case (h)
      4'h0: p = 8'hFC; 4'h1: p = 8'h60; 4'h2: p = 8'hDA; 4'h3: p = 8'hF2;
      4'h4: p = 8'h66; 4'h5: p = 8'hB6; 4'h6: p = 8'hBE; 4'h7: p = 8'hE0;
      4'h8: p = 8'hFE; 4'h9: p = 8'hF6; 4'hA: p = 8'hEE; 4'hB: p = 8'h3E;
      4'hC: p = 8'h9C; 4'hD: p = 8'h7A; 4'hE: p = 8'h9E; default: p = 8'h8E;
    endcase
    return ~p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected reaction to one good byte, from the make/break rules.
  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) return;
    if (b == 8'hF0) begin
      m_state = 2;
      return;
    end
    if (m_state == 2) begin
      m_state = 0;
      m_code  = 8'h00;
    end else if (m_state == 0 || b != m_code) begin
      m_state = 1;
      m_code  = b;
      m_count = m_count + 8'd1;
      exp_q.push_back(press_t'{code: b, count: m_count});
    end
  endtask

  // kind: 0 good, 1 parity flipped, 2 stop bit low
  task automatic send_frame(input logic [7:0] b, input int kind, input int nbits);
    logic [10:0] f;
    f = {1'b1, ~^b, b, 1'b0};
    if (kind == 1) f[9]  = ~f[9];
    if (kind == 2) f[10] = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      cyc(H);
      ps2_clk = 1'b0;
      cyc(H);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cyc(10);
  endtask

  task automatic key(input logic [7:0] b);
    model_byte(b);
    send_frame(b, 0, 11);
  endtask

  task automatic bad(input logic [7:0] b, input int kind);
    m_err = 1'b1;
    send_frame(b, kind, 11);
  endtask

  task automatic check_state(input string tag);
    logic [15:0] exp_code_seg;
    exp_code_seg = (m_state == 1) ? {font(m_code[7:4]), font(m_code[3:0])} : 16'hFFFF;
    check({tag, " key_code"}, 32'(key_code), 32'(m_code));
    check({tag, " frame_err"}, 32'(frame_err), 32'(m_err));
    check({tag, " seg_1/0"}, 32'({seg_1, seg_0}), 32'(exp_code_seg));
    check({tag, " seg_5/4"}, 32'({seg_5, seg_4}),
          32'({font(m_count[7:4]), font(m_count[3:0])}));
    check({tag, " blanks"}, {seg_7, seg_6, seg_3, seg_2}, 32'hFFFF_FFFF);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    m_state = 0;
    m_code  = 8'h00;
    m_count = 8'h00;
    m_err   = 1'b0;
    exp_q.delete();
    cyc(3);
    check({tag, " key_valid"}, 32'(key_valid), 32'd0);
    check_state(tag);
    rst = 1'b1;
    cyc(3);
  endtask

  // Scoreboard monitor: every key_valid pulse must match the next queued press.
  always @(negedge clk) begin
    press_t p;
    if (rst && key_valid) begin
      if (exp_q.size() == 0) begin
        check("key_valid with no press queued", 32'(key_valid), 32'd0);
      end else begin
        p = exp_q.pop_front();
        check("press key_code", 32'(key_code), 32'(p.code));
        check("press count", 32'({seg_5, seg_4}), 32'({font(p.count[7:4]), font(p.count[3:0])}));
      end
    end
  end

  initial begin
    logic [7:0] b;
    int r;
    do_reset("reset");
    cyc(20);
    check_state("idle");

    key(8'h1C);
    check_state("press 1C");
    for (int i = 0; i < 3; i++) key(8'h1C);
    check_state("repeat 1C");
    key(8'hF0);
    check_state("break prefix");
    key(8'h1C);
    check_state("released 1C");

    bad(8'h1C, 1);
    check_state("bad parity");

    key(8'hE0); key(8'h75);
    check_state("ext press 75");
    key(8'hE0); key(8'hF0); key(8'h75);
    check_state("ext release 75");

    // Reset in the middle of a frame, then a clean frame must decode.
    send_frame(8'h55, 0, 4);
    do_reset("mid-frame reset");
    key(8'h4D);
    check_state("after reset 4D");
    key(8'hF0); key(8'h4D);

    // Abandoned frame followed by a full one.
    send_frame(8'h29, 0, 5);
    cyc(TO + 10);
    key(8'h29);
    check_state("after timeout 29");

    bad(8'h33, 2);
    check_state("bad stop");

    do_reset("reset 2");
    for (int i = 0; i < 256; i++) begin
      b = 8'((i % 96) + 1);
      key(b); key(8'hF0); key(b);
    end
    check_state("count wrap");

    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0: key(8'hF0);
        1: key(8'hE0);
        2: key(m_code);
        3: bad(8'($urandom_range(0, 255)), int'($urandom_range(1, 2)));
        default: key(8'($urandom_range(0, 255)));
      endcase
      check_state("random");
    end

    cyc(20);
    check("presses outstanding", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
